spi_cmd_receiver: RTL and testbench
===================================

# spi_cmd_receiver

SPI slave command front end for the tiny shader. It samples the external SPI pins in the system clock domain, assembles MSB-first bytes, and decodes a one-byte command per transaction. Commands write the shader instruction memory, write a control register, or stream the instruction memory back on MISO. It sits between the `uio_in[0]`/`uio_in[1]`/`uio_in[3]`/`uio_out[2]` pad pins and the shader core's instruction memory and register file.

## Interface
Parameters:
- `MEM_DEPTH` = 32: instruction memory entries; must be a power of two, ≥ 2.
- `ADDR_W` = $clog2(MEM_DEPTH): memory address width.

Ports:
- `clk_i` in 1: system clock; the only clock.
- `rst_i` in 1: reset; asynchronous, active-high.
- `spi_sclk_i` in 1: SPI clock, asynchronous to `clk_i`, mode 0 (CPOL=0, CPHA=0).
- `spi_mosi_i` in 1: SPI data in, asynchronous.
- `spi_cs_i` in 1: chip select, active-low, asynchronous.
- `spi_miso_o` out 1: SPI data out, registered.
- `mem_we_o` out 1: one-cycle instruction-memory write strobe.
- `mem_waddr_o` out ADDR_W: write address.
- `mem_wdata_o` out 8: write data.
- `mem_raddr_o` out ADDR_W: read address.
- `mem_rdata_i` in 8: read data, valid 1 clk after `mem_raddr_o` changes.
- `reg_we_o` out 1: one-cycle register write strobe.
- `reg_addr_o` out 4: register index.
- `reg_wdata_o` out 8: register data.
- `busy_o` out 1: high while a transaction is active (synchronised CS low).

## Operation
- Synchronisers: each of `spi_sclk_i`, `spi_mosi_i`, `spi_cs_i` passes through 2 flops, plus a third flop on SCLK and CS for edge detection. Resets: SCLK 0, MOSI 0, CS 1.
- A detected SCLK rising edge samples the synchronised MOSI into the RX shift register, MSB first. A detected falling edge shifts the TX register onto `spi_miso_o`.
- A 3-bit bit counter clears on CS assertion. The 8th rising edge completes a byte.
- States:
  - IDLE: CS high.
  - CMD: entered on CS fall.
  - WR_MEM, REG_ADDR, REG_DATA, RD_MEM: command phases.
  - DISCARD: ignore bytes until CS rises.
- Command byte:
  - 0x00 → WR_MEM.
  - 0x01 → REG_ADDR.
  - 0x02 → RD_MEM.
  - Any other value → DISCARD.
- WR_MEM:
  - Each completed byte drives `mem_wdata_o` and `mem_waddr_o` and pulses `mem_we_o`.
  - The write address starts at 0 in every transaction and increments after each write.
  - The address wraps from MEM_DEPTH-1 to 0.
- REG_ADDR / REG_DATA:
  - The first byte's low nibble is latched into `reg_addr_o`; the upper nibble is ignored.
  - The second byte drives `reg_wdata_o` and pulses `reg_we_o`.
  - The FSM then goes to DISCARD.
- RD_MEM:
  - `mem_raddr_o` is set to 0 when the command byte completes.
  - On the next falling edge after each byte boundary, the TX register loads `mem_rdata_i` and bit 7 is driven.
  - `mem_raddr_o` then increments, with the same wrap rule as writes.
- `spi_miso_o` is 0 in IDLE, CMD, WR_MEM, REG_*, and DISCARD.
- CS rise in any state returns the FSM to IDLE. A partial byte is discarded and no strobe is issued. Addresses are not retained across transactions.
- A CS fall and an SCLK edge detected in the same clk: the CS fall wins and the SCLK edge is ignored.

## Timing
- Requirements on the SPI master:
  - f_sclk ≤ f_clk/8.
  - CS setup to the first SCLK rise ≥ 4 clk.
  - CS hold after the last SCLK fall ≥ 4 clk.
- Pin edge to internal edge detect: 3 clk. MOSI uses the same path, so the sampled data is aligned with the detected edge.
- `mem_we_o` / `reg_we_o`: high exactly 1 clk, in the clk after the detected 8th rising edge. Data and address outputs are stable in that cycle and hold until the next write.
- `spi_miso_o` change: 1 clk after the detected falling edge, i.e. ≤ 4 clk after the pin edge.
- `busy_o`: rises 3 clk after CS fall and falls 3 clk after CS rise.
- Reset values:
  - All strobes 0.
  - `mem_waddr_o`, `mem_raddr_o`, `reg_addr_o` are 0.
  - `mem_wdata_o`, `reg_wdata_o` are 0.
  - `spi_miso_o` 0, `busy_o` 0, FSM in IDLE.
- Reset asserted mid-transaction aborts immediately: no strobe is issued. After release, the block waits in IDLE for a fresh CS fall.

## Test plan
- Reset: assert `rst_i` mid-WR_MEM byte → all outputs return to their reset values immediately; no `mem_we_o` pulse follows.
- Memory write: CS low, send 0x00, 0xA5, 0x3C, then CS high →
  - Exactly two `mem_we_o` pulses: (addr 0, 0xA5) then (addr 1, 0x3C).
  - Each pulse lasts 1 clk.
- Wrap (MEM_DEPTH=32): send 0x00 followed by 33 data bytes → the 33rd write goes to addr 0.
- Register write: send 0x01, 0xF7, 0x42 → one `reg_we_o` pulse with `reg_addr_o`=7 and `reg_wdata_o`=0x42. A further byte 0x99 causes no strobe.
- Memory read: preload mem[0]=0x81 and mem[1]=0x5A, then send 0x02 followed by 16 dummy clocks → the master samples 0x81 then 0x5A on MISO.
- Abort and illegal command:
  - CS rises after 5 bits of a data byte in WR_MEM → no strobe.
  - Command 0x7E followed by 2 bytes → no strobe and MISO stays 0.
  - A following 0x00, 0x11 transaction writes 0x11 to addr 0.

Source files
------------

// File: rtl/spi_cmd_receiver.sv
// SPI mode-0 slave command decoder: memory write, register write, memory read-back.
// Latency: pin edge to edge detect 3 clk; write strobes 1 clk after the 8th rising edge; MISO 1 clk after falling edge.
// Backpressure: none, the SPI master paces everything and the block never stalls.
module spi_cmd_receiver #(
    parameter int MEM_DEPTH = 32,
    parameter int ADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              spi_sclk_i,
    input  logic              spi_mosi_i,
    input  logic              spi_cs_i,
    output logic              spi_miso_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_waddr_o,
    output logic [7:0]        mem_wdata_o,
    output logic [ADDR_W-1:0] mem_raddr_o,
    input  logic [7:0]        mem_rdata_i,
    output logic              reg_we_o,
    output logic [3:0]        reg_addr_o,
    output logic [7:0]        reg_wdata_o,
    output logic              busy_o
);

    typedef enum logic [2:0] {
        IDLE, CMD, WR_MEM, REG_ADDR, REG_DATA, RD_MEM, DISCARD
    } state_t;

    state_t            state, state_nxt;
    logic [2:0]        sclk_sync;
    logic [2:0]        cs_sync;
    logic [1:0]        mosi_sync;
    logic [2:0]        bit_cnt;
    logic [6:0]        rx_sh;
    logic [6:0]        tx_sh;
    logic [ADDR_W-1:0] wr_ptr;
    logic              load_pend;

    logic       sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic       active, byte_done;
    logic [7:0] rx_byte;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
        end else begin
            sclk_sync <= {sclk_sync[1:0], spi_sclk_i};
            cs_sync   <= {cs_sync[1:0], spi_cs_i};
            mosi_sync <= {mosi_sync[0], spi_mosi_i};
        end
    end

    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
    assign cs_fall   = ~cs_sync[1] & cs_sync[2];
    assign cs_rise   = cs_sync[1] & ~cs_sync[2];
    // A CS edge in the same clk masks any SCLK edge.
    assign active    = (state != IDLE) & ~cs_rise & ~cs_fall;
    assign byte_done = active & sclk_rise & (bit_cnt == 3'd7);
    assign rx_byte   = {rx_sh, mosi_sync[1]};
    assign busy_o    = (state != IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (cs_fall) state_nxt = CMD;
            CMD: begin
                if (byte_done) begin
                    case (rx_byte)
                        8'h00:   state_nxt = WR_MEM;
                        8'h01:   state_nxt = REG_ADDR;
                        8'h02:   state_nxt = RD_MEM;
                        default: state_nxt = DISCARD;
                    endcase
                end
            end
            REG_ADDR: if (byte_done) state_nxt = REG_DATA;
            REG_DATA: if (byte_done) state_nxt = DISCARD;
            default:  state_nxt = state;
        endcase
        if ((state != IDLE) && cs_rise) state_nxt = IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bit_cnt     <= '0;
            rx_sh       <= '0;
            tx_sh       <= '0;
            wr_ptr      <= '0;
            load_pend   <= 1'b0;
            spi_miso_o  <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_waddr_o <= '0;
            mem_wdata_o <= '0;
            mem_raddr_o <= '0;
            reg_we_o    <= 1'b0;
            reg_addr_o  <= '0;
            reg_wdata_o <= '0;
        end else begin
            mem_we_o <= 1'b0;
            reg_we_o <= 1'b0;

            if (cs_fall) begin
                bit_cnt   <= '0;
                wr_ptr    <= '0;
                load_pend <= 1'b0;
            end else if (active && sclk_rise) begin
                bit_cnt <= bit_cnt + 3'd1;
                rx_sh   <= rx_byte[6:0];
            end

            if (byte_done) begin
                case (state)
                    CMD: begin
                        if (rx_byte == 8'h02) begin
                            mem_raddr_o <= '0;
                            load_pend   <= 1'b1;
                        end
                    end
                    WR_MEM: begin
                        mem_we_o    <= 1'b1;
                        mem_waddr_o <= wr_ptr;
                        mem_wdata_o <= rx_byte;
                        wr_ptr      <= wr_ptr + ADDR_W'(1);
                    end
                    REG_ADDR: reg_addr_o <= rx_byte[3:0];
                    REG_DATA: begin
                        reg_we_o    <= 1'b1;
                        reg_wdata_o <= rx_byte;
                    end
                    RD_MEM:   load_pend <= 1'b1;
                    default:  ;
                endcase
            end

            // The first falling edge after a byte boundary fetches the next memory word.
            if (state != RD_MEM) begin
                spi_miso_o <= 1'b0;
            end else if (sclk_fall) begin
                if (load_pend) begin
                    spi_miso_o  <= mem_rdata_i[7];
                    tx_sh       <= mem_rdata_i[6:0];
                    mem_raddr_o <= mem_raddr_o + ADDR_W'(1);
                    load_pend   <= 1'b0;
                end else begin
                    spi_miso_o <= tx_sh[6];
                    tx_sh      <= {tx_sh[5:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_receiver.sv
// Directed bench for spi_cmd_receiver: transaction-level expectation queues plus literal pins.
module tb_spi_cmd_receiver;
    localparam int MEM_DEPTH = 32;
    localparam int ADDR_W    = 5;
    localparam int HALF      = 5;

    logic              clk_i      = 1'b0;
    logic              rst_i      = 1'b1;
    logic              spi_sclk_i = 1'b0;
    logic              spi_mosi_i = 1'b0;
    logic              spi_cs_i   = 1'b1;
    logic              spi_miso_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_waddr_o;
    logic [7:0]        mem_wdata_o;
    logic [ADDR_W-1:0] mem_raddr_o;
    logic [7:0]        mem_rdata_i;
    logic              reg_we_o;
    logic [3:0]        reg_addr_o;
    logic [7:0]        reg_wdata_o;
    logic              busy_o;

    spi_cmd_receiver #(.MEM_DEPTH(MEM_DEPTH)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .spi_sclk_i  (spi_sclk_i),
        .spi_mosi_i  (spi_mosi_i),
        .spi_cs_i    (spi_cs_i),
        .spi_miso_o  (spi_miso_o),
        .mem_we_o    (mem_we_o),
        .mem_waddr_o (mem_waddr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_raddr_o (mem_raddr_o),
        .mem_rdata_i (mem_rdata_i),
        .reg_we_o    (reg_we_o),
        .reg_addr_o  (reg_addr_o),
        .reg_wdata_o (reg_wdata_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    logic [7:0]        tb_mem [MEM_DEPTH];
    logic [ADDR_W+7:0] exp_mem_q [$];
    logic [11:0]       exp_reg_q [$];
    logic [ADDR_W+7:0] me;
    logic [11:0]       re;
    int checks = 0, errors = 0, mem_pulses = 0, reg_pulses = 0;
    bit   rd_active = 1'b0;
    logic prev_mwe = 1'b0, prev_rwe = 1'b0;

    always @(posedge clk_i) mem_rdata_i <= tb_mem[mem_raddr_o];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Every cycle: strobes must match the expectation queues, MISO quiet outside reads.
    always @(posedge clk_i) begin
        #1;
        if (!rst_i) begin
            if (mem_we_o) begin
                mem_pulses++;
                check("mem_we_width", 32'(prev_mwe), 32'd0);
                if (exp_mem_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL mem_we_unexpected: got strobe addr %0d data 0x%0h, expected none", mem_waddr_o, mem_wdata_o);
                end else begin
                    me = exp_mem_q.pop_front();
                    check("mem_waddr", 32'(mem_waddr_o), 32'(me[ADDR_W+7:8]));
                    check("mem_wdata", 32'(mem_wdata_o), 32'(me[7:0]));
                end
            end
            if (reg_we_o) begin
                reg_pulses++;
                check("reg_we_width", 32'(prev_rwe), 32'd0);
                if (exp_reg_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL reg_we_unexpected: got strobe addr %0d data 0x%0h, expected none", reg_addr_o, reg_wdata_o);
                end else begin
                    re = exp_reg_q.pop_front();
                    check("reg_addr", 32'(reg_addr_o), 32'(re[11:8]));
                    check("reg_wdata", 32'(reg_wdata_o), 32'(re[7:0]));
                end
            end
            if (!rd_active) check("miso_quiet", 32'(spi_miso_o), 32'd0);
        end
        prev_mwe = mem_we_o;
        prev_rwe = reg_we_o;
    end

    task automatic model_txn(input logic [7:0] b[$]);
        if (b.size() == 0) return;
        if (b[0] == 8'h00) begin
            for (int i = 1; i < b.size(); i++)
                exp_mem_q.push_back({ADDR_W'((i - 1) % MEM_DEPTH), b[i]});
        end else if (b[0] == 8'h01 && b.size() >= 3) begin
            exp_reg_q.push_back({b[1][3:0], b[2]});
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic xfer_bit(input logic d, output logic q);
        spi_mosi_i = d;
        wait_clk(HALF);
        q = spi_miso_o;
        spi_sclk_i = 1'b1;
        wait_clk(HALF);
        spi_sclk_i = 1'b0;
    endtask

    task automatic cs_low();
        spi_cs_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 check("busy_rise_early", 32'(busy_o), 32'd0);
        @(posedge clk_i);
        #1 check("busy_rise", 32'(busy_o), 32'd1);
        wait_clk(HALF);
    endtask

    task automatic cs_high();
        wait_clk(HALF);
        spi_cs_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1 check("busy_fall_early", 32'(busy_o), 32'd1);
        @(posedge clk_i);
        #1 check("busy_fall", 32'(busy_o), 32'd0);
        wait_clk(8);
    endtask

    task automatic spi_txn(input logic [7:0] b[$], input int tail_bits, output logic [7:0] rx[$]);
        logic [7:0] r;
        logic       q;
        rx = {};
        r  = '0;
        model_txn(b);
        cs_low();
        foreach (b[i]) begin
            for (int k = 7; k >= 0; k--) begin
                xfer_bit(b[i][k], q);
                r[k] = q;
            end
            rx.push_back(r);
        end
        for (int k = 0; k < tail_bits; k++) xfer_bit(1'b1, q);
        cs_high();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_mem_we"},    32'(mem_we_o),    32'd0);
        check({tag, "_reg_we"},    32'(reg_we_o),    32'd0);
        check({tag, "_mem_waddr"}, 32'(mem_waddr_o), 32'd0);
        check({tag, "_mem_wdata"}, 32'(mem_wdata_o), 32'd0);
        check({tag, "_mem_raddr"}, 32'(mem_raddr_o), 32'd0);
        check({tag, "_reg_addr"},  32'(reg_addr_o),  32'd0);
        check({tag, "_reg_wdata"}, 32'(reg_wdata_o), 32'd0);
        check({tag, "_miso"},      32'(spi_miso_o),  32'd0);
        check({tag, "_busy"},      32'(busy_o),      32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] tx[$];
        logic [7:0] rx[$];
        logic       q;

        for (int i = 0; i < MEM_DEPTH; i++) tb_mem[i] = 8'(i * 3 + 1);
        tb_mem[0] = 8'h81;
        tb_mem[1] = 8'h5A;

        wait_clk(3);
        check_reset_vals("rst_init");
        rst_i = 1'b0;
        wait_clk(5);

        // Memory write: two bytes to addr 0 and 1.
        tx = {8'h00, 8'hA5, 8'h3C};
        spi_txn(tx, 0, rx);
        check("wr_pulses", 32'(mem_pulses), 32'd2);
        check("wr_last_addr", 32'(mem_waddr_o), 32'd1);
        check("wr_last_data", 32'(mem_wdata_o), 32'h3C);

        // Register write, trailing byte ignored.
        tx = {8'h01, 8'hF7, 8'h42, 8'h99};
        spi_txn(tx, 0, rx);
        check("reg_pulses", 32'(reg_pulses), 32'd1);
        check("reg_addr_lit", 32'(reg_addr_o), 32'd7);
        check("reg_wdata_lit", 32'(reg_wdata_o), 32'h42);

        // 33 data bytes: the last one wraps to addr 0.
        tx = {8'h00};
        for (int i = 1; i <= 33; i++) tx.push_back(8'(i * 5));
        spi_txn(tx, 0, rx);
        check("wrap_pulses", 32'(mem_pulses), 32'd35);
        check("wrap_addr", 32'(mem_waddr_o), 32'd0);
        check("wrap_data", 32'(mem_wdata_o), 32'hA5);

        // Memory read-back.
        rd_active = 1'b1;
        tx = {8'h02, 8'h00, 8'h00};
        spi_txn(tx, 0, rx);
        rd_active = 1'b0;
        check("rd_byte0_lit", 32'(rx[1]), 32'h81);
        check("rd_byte1_lit", 32'(rx[2]), 32'h5A);
        for (int i = 1; i < 3; i++) check("rd_byte_model", 32'(rx[i]), 32'(tb_mem[i - 1]));

        // Abort after 5 bits of a data byte.
        tx = {8'h00};
        spi_txn(tx, 5, rx);
        check("abort_pulses", 32'(mem_pulses), 32'd35);

        // Illegal command.
        tx = {8'h7E, 8'h12, 8'h34};
        spi_txn(tx, 0, rx);
        check("illegal_mem_pulses", 32'(mem_pulses), 32'd35);
        check("illegal_reg_pulses", 32'(reg_pulses), 32'd1);

        // Fresh transaction restarts at addr 0.
        tx = {8'h00, 8'h11};
        spi_txn(tx, 0, rx);
        check("fresh_pulses", 32'(mem_pulses), 32'd36);
        check("fresh_addr", 32'(mem_waddr_o), 32'd0);
        check("fresh_data", 32'(mem_wdata_o), 32'h11);

        // Reset in the middle of a WR_MEM data byte.
        cs_low();
        for (int k = 7; k >= 0; k--) xfer_bit(1'b0, q);
        for (int k = 0; k < 4; k++) xfer_bit(1'b1, q);
        rst_i      = 1'b1;
        spi_cs_i   = 1'b1;
        spi_sclk_i = 1'b0;
        #1;
        check_reset_vals("rst_mid");
        wait_clk(4);
        rst_i = 1'b0;
        wait_clk(30);
        check("post_reset_pulses", 32'(mem_pulses), 32'd36);
        check("post_reset_busy", 32'(busy_o), 32'd0);

        check("mem_queue_drained", 32'(exp_mem_q.size()), 32'd0);
        check("reg_queue_drained", 32'(exp_reg_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
